// File: rtl/fetch_prefetch_queue_if.sv
// Fetch stage bundle: I-side memory port A, redirect input and decode-facing queue head.
// master = fetch stage, slave = memory/decode environment.
interface fetch_prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: port A holds read_a/address_a stable until the cycle resp_a is
  // high (that cycle ends the request, rdata_a valid then); the head entry moves
  // to decode in any cycle where out_valid & out_ready are both high.
  logic            read_a;
  logic [XLEN-1:0] address_a;
  logic            resp_a;
  logic [XLEN-1:0] rdata_a;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [CW-1:0]   out_count;

  modport master (
    output read_a, address_a,
    input  resp_a, rdata_a,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr, out_count,
    input  out_ready
  );

  modport slave (
    input  read_a, address_a,
    output resp_a, rdata_a,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr, out_count,
    output out_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: PC generation, single-outstanding read on port A, DEPTH-entry queue.
// Optional macro FETCH_BYPASS_EN: empty-queue responses reach decode in the same cycle.
module fetch_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  fetch_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_addr;
  logic            r_read_a;
  logic            r_drop;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc_q    [DEPTH];
  logic [XLEN-1:0] r_instr_q [DEPTH];

  logic            w_resp;
  logic            w_accept;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;
  logic [XLEN-1:0] w_redir_pc;

  assign w_redir_pc = bus.redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign w_resp     = bus.resp_a & r_read_a;
  assign w_accept   = w_resp & ~r_drop & ~bus.redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_accept & (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word taken by decode this cycle never occupies a queue slot.
  assign w_push  = w_accept & ~(w_bypass & bus.out_ready);
  assign w_pop   = (r_count != '0) & bus.out_ready & ~bus.redirect_valid;
  // A redirect empties the queue, so it always frees room for the new fetch.
  assign w_issue = ~r_read_a & (bus.redirect_valid | (r_count < CW'(DEPTH)));

  assign bus.read_a    = r_read_a;
  assign bus.address_a = r_addr;
  assign bus.out_valid = (r_count != '0) | w_bypass;
  assign bus.out_pc    = w_bypass ? r_addr      : r_pc_q[r_head];
  assign bus.out_instr = w_bypass ? bus.rdata_a : r_instr_q[r_head];
  assign bus.out_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_read_a   <= 1'b0;
      r_drop     <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]    <= '0;
        r_instr_q[i] <= '0;
      end
    end else begin
      if (r_read_a) begin
        if (bus.resp_a) r_read_a <= 1'b0;
      end else if (w_issue) begin
        r_read_a <= 1'b1;
        r_addr   <= bus.redirect_valid ? w_redir_pc : r_fetch_pc;
      end

      if (bus.redirect_valid)  r_fetch_pc <= w_redir_pc;
      else if (w_accept)       r_fetch_pc <= r_fetch_pc + XLEN'(4);

      // Only the response of a request that outlives the redirect is stale.
      if (bus.redirect_valid)  r_drop <= r_read_a & ~bus.resp_a;
      else if (w_resp)         r_drop <= 1'b0;

      if (bus.redirect_valid) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_pc_q[r_tail]    <= r_addr;
          r_instr_q[r_tail] <= bus.rdata_a;
          r_tail            <= r_tail + PW'(1);
        end
        if (w_pop) r_head <= r_head + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Parametrised next-generation instruction fetch stage with PC generation, a single-outstanding memory read port and a DEPTH-entry instruction queue.
- Decouples I-cache latency from decode; sits between the I-side memory port (port A) and the decode stage register.
- Accepts a redirect (branch/jump/trap target) that flushes queued instructions and discards any in-flight response.

Parameters:
- XLEN, 32, width of PC, address and instruction word.
- DEPTH, 4, queue entries; power of 2, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read_a  out  1  memory read request; held high until resp_a.
- address_a  out  XLEN  read address; stable while read_a high.
- resp_a  in  1  memory response; rdata_a valid this cycle and ends the request.
- rdata_a  in  XLEN  instruction word returned.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] forced to 0.
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode accepts head entry this cycle.
- out_pc  out  XLEN  PC of head instruction.
- out_instr  out  XLEN  head instruction word.
- out_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty (head=tail=count=0), pending=0, drop=0; outputs read_a=0, out_valid=0, out_count=0, address_a=RESET_PC, out_pc/out_instr=0. Reset mid-request abandons it; a resp_a arriving after reset with no request is ignored.
- Issue: read_a=1 when no request pending and count+pending < DEPTH (count excludes entries leaving this cycle; no look-ahead on pop). address_a=fetch_pc, held until resp_a. First request in first cycle after rst_n rises.
- resp_a may arrive in the same cycle read_a rises (zero-wait memory). resp_a while read_a=0 is ignored.
- Response (resp_a & read_a): if drop=0 and no redirect this cycle, push {address_a, rdata_a} at tail; fetch_pc <= fetch_pc+4 (wraps mod 2^XLEN). New request may issue next cycle: peak 1 instr / 2 cycles to queue when memory always same-cycle.
- Pop: out_valid & out_ready advances head. Push and pop in the same cycle leave count unchanged; full queue never overflows because issue is gated.
- Output: out_valid = (count != 0); out_pc/out_instr come from the head register (1-cycle latency resp_a -> out_valid).
- Redirect (highest priority): in cycle of redirect_valid, queue cleared (count=0 next cycle, any pop ignored), fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}. If a request is outstanding and resp_a not asserted, read_a/address_a stay unchanged until resp_a; drop=1 and that response is discarded, drop cleared on it. If resp_a coincides with redirect, that data is discarded and drop stays 0. The redirected fetch issues in the cycle after the bus is free.
- Back-to-back redirects: last one wins; drop remains a single bit (only one request ever outstanding).
- Pointers wrap mod DEPTH.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when count==0, resp_a&read_a, drop=0 and no redirect, out_valid=1 combinationally with out_pc=address_a, out_instr=rdata_a. If out_ready=1 the entry is consumed and not enqueued; otherwise it is enqueued normally. Zero-cycle fetch latency.
- Undefined: strict 1-cycle latency as above; out_valid depends only on registered state.

Test Plan:
- Reset release, memory responds same cycle, out_ready=1 -> address_a 0x0,0x4,0x8 in order; out_pc/out_instr match, out_valid 1 cycle after each resp_a (without bypass).
- out_ready=0, DEPTH=4 -> exactly 4 responses queued, read_a stays 0, out_count=4; raise out_ready -> 4 pops in order, fetch resumes at 0x10.
- Redirect to 0x103 while request to 0x8 is pending with 3-cycle memory latency -> read_a/address 0x8 held until resp, data dropped, next address_a=0x100, queue empty, no stale out_valid.
- Redirect in same cycle as resp_a and pop with count=2 -> count=0 next cycle, response discarded, next fetch 0x100-target.
- fetch_pc=0xFFFF_FFFC response -> next address_a=0x0000_0000.
- FETCH_BYPASS_EN defined, queue empty, resp_a with rdata 0x00000013 and out_ready=1 -> out_valid same cycle, out_count stays 0.
